usb_decode: RTL and testbench
=============================

Name: usb_decode

Overview:
- Receive-side packet decoder for the USB device core.
- Consumes the byte stream from the ULPI receive path, one packet per tlast-terminated burst.
- Validates each PID and classifies the packet as handshake, token or data.
- Checks CRC5 on tokens and CRC16 on data, then presents handshake/token strobes and a CRC-stripped payload stream to the protocol/endpoint layer.
- It is the receive counterpart of the transmit encoder and uses the same type encodings.

Parameters:
- none.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_tvalid_i  in  1  receive byte valid
- rx_tready_o  out  1  receive ready; 1 whenever not in reset, because the decoder never stalls
- rx_tlast_i  in  1  last byte of packet
- rx_tdata_i  in  8  receive byte
- hsk_recv_o  out  1  1-cycle strobe: valid handshake received
- hsk_type_o  out  2  PID[3:2]: 00 ACK, 10 NAK, 11 STALL, 01 NYET
- tok_recv_o  out  1  1-cycle strobe: valid token received
- tok_type_o  out  2  PID[3:2]: 00 OUT, 01 SOF, 10 IN, 11 SETUP
- tok_addr_o  out  7  device address (for SOF, frame[6:0])
- tok_endp_o  out  4  endpoint (for SOF, frame[10:7])
- trn_start_o  out  1  1-cycle strobe: data PID accepted
- trn_type_o  out  2  PID[3:2]: 00 DATA0, 10 DATA1, 01 DATA2, 11 MDATA
- trn_tvalid_o  out  1  payload byte valid; no backpressure
- trn_tlast_o  out  1  last payload byte
- trn_tdata_o  out  8  payload byte
- trn_end_o  out  1  1-cycle strobe: data packet complete
- trn_crc_err_o  out  1  CRC16 mismatch; valid while trn_end_o=1
- rx_err_o  out  1  1-cycle strobe: malformed packet, bad PID or CRC5 error

Behaviour:
- Reset: all strobes, valids, rx_tready_o and trn_crc_err_o are 0. Type/addr/endp/data outputs are 0. FSM goes to IDLE and the delay buffer empties.
- Reset mid-packet discards the packet with no strobes. The first valid byte after reset is treated as a PID; the ULPI layer guarantees packet alignment.
- Bubbles (rx_tvalid_i=0) may appear anywhere inside a packet; all counting is per accepted byte.
- PID check: valid iff rx_tdata_i[7:4] == ~rx_tdata_i[3:0]. Class is taken from PID[1:0]: 10 handshake, 01 token, 11 data, 00 special.
- IDLE, on an accepted byte:
  - Bad PID: go to DROP, or if tlast, pulse rx_err_o next cycle.
  - Handshake with tlast: hsk_recv_o=1 next cycle, hsk_type_o latched.
  - Handshake without tlast: DROP, with error at tlast.
  - Token: latch tok_type_o, go to TOK1.
  - Data: trn_start_o=1 next cycle, trn_type_o latched, go to DATA.
  - Special PID (PING/SPLIT/PRE/ERR): DROP silently, no error.
  - Any PID that ends early (tlast, except a handshake) pulses rx_err_o.
- TOK1: capture byte 1. tlast here is an error and returns to IDLE.
- TOK2: capture byte 2.
  - Requires tlast; otherwise DROP with error.
  - CRC5 runs over the 16 bits of bytes 1–2, LSB first, init 5'b11111. Valid iff the residual is 5'b01100.
  - If valid: tok_addr_o = b1[6:0], tok_endp_o = {b2[2:0], b1[7]}, tok_recv_o=1 the cycle after the byte-2 accept.
  - If invalid: rx_err_o=1 instead and token fields are unchanged.
- DATA uses a 2-byte delay buffer (buf0 older, buf1 newer).
  - Byte k of the payload is emitted one cycle after byte k+2 of the packet body is accepted, so the 2 CRC bytes are never emitted.
  - CRC16 state (init 16'hFFFF) updates with each emitted byte.
- DATA, on accepted byte with tlast and buffer full (≥1 payload byte):
  - Next cycle: emit buf0 with trn_tlast_o=1 and trn_end_o=1.
  - trn_crc_err_o = ({rx_tdata_i, buf1} != ~bitrev(crc16(buf0, crc_q))), i.e. the same ordering the encoder transmits: low byte first.
- Zero-length data packet (exactly 2 body bytes):
  - trn_tvalid_o never asserts.
  - trn_end_o pulses the cycle after the 2nd CRC byte; the check is against ~bitrev(16'hFFFF) = 16'h0000.
- Data body of 0 or 1 bytes before tlast: rx_err_o=1 instead of trn_end_o, no trn_tlast_o, return to IDLE.
- DROP: ignore bytes until tlast, then return to IDLE and pulse rx_err_o if an error was flagged.
- All outputs are registered. Strobes are exactly 1 cycle. Back-to-back packets are accepted with no idle cycle between them.

Decomposition:
- Shared include (usb_crc.vh, already used by the encoder): crc5/crc16 functions, plus new PID class/type constants (HSK/TOK/DATA/SPECIAL, ACK/NAK/STALL/NYET, OUT/SOF/IN/SETUP, DATA0/1/2/MDATA). The encoder switches to these constants too.
- One natural sub-module: usb_crc16_strip. It holds the 2-byte delay buffer, the CRC16 accumulate and the end-of-packet compare, with ports byte-in/valid/last, byte-out/valid/last, end, err.

Test Plan:
- ACK: byte 0xD2 with tlast -> hsk_recv_o=1 for one cycle, hsk_type_o=00; no other strobes.
- SETUP to addr 0, endp 0: bytes 0x2D, 0x00, 0x10 (tlast) -> tok_recv_o=1, tok_type_o=11, tok_addr_o=0, tok_endp_o=0. Corrupting byte 3 to 0x11 -> rx_err_o=1, no tok_recv_o.
- Zero-length DATA1: 0x4B, 0x00, 0x00 (tlast) -> trn_start_o with trn_type_o=10, then trn_end_o with trn_crc_err_o=0 and no trn_tvalid_o.
- DATA0 with 8 random bytes plus bench-model CRC, random rx_tvalid_i bubbles -> 8 bytes out in order, tlast on the 8th, trn_end_o coincident, crc_err=0. Flipping one payload bit -> same stream with crc_err=1.
- Bad PID 0xC4 with two more bytes, tlast -> one rx_err_o at the end, no other strobes. An immediately following ACK decodes correctly.
- Reset asserted mid-DATA packet, then a clean ACK -> no trn_end_o, and hsk_recv_o fires for the ACK.

Source files
------------

// File: rtl/usb_decode_pkg.sv
// Shared USB receive/transmit definitions: PID classes and types, decoder
// states, and the CRC5/CRC16 helpers used on both sides of the wire.
package usb_decode_pkg;

    typedef enum logic [1:0] {
        PID_SPECIAL = 2'b00,
        PID_TOK     = 2'b01,
        PID_HSK     = 2'b10,
        PID_DATA    = 2'b11
    } pid_class_e;

    typedef enum logic [1:0] {
        HSK_ACK   = 2'b00,
        HSK_NYET  = 2'b01,
        HSK_NAK   = 2'b10,
        HSK_STALL = 2'b11
    } hsk_type_e;

    typedef enum logic [1:0] {
        TOK_OUT   = 2'b00,
        TOK_SOF   = 2'b01,
        TOK_IN    = 2'b10,
        TOK_SETUP = 2'b11
    } tok_type_e;

    typedef enum logic [1:0] {
        DAT_DATA0 = 2'b00,
        DAT_DATA2 = 2'b01,
        DAT_DATA1 = 2'b10,
        DAT_MDATA = 2'b11
    } dat_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOK1,
        ST_TOK2,
        ST_DATA,
        ST_DROP
    } state_t;

    localparam logic [4:0]  CRC5_INIT     = 5'b11111;
    localparam logic [4:0]  CRC5_RESIDUAL = 5'b01100;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;

    // Serial CRC5 (x^5+x^2+1), bit 0 of d enters first.
    function automatic logic [4:0] crc5(input logic [15:0] d, input logic [4:0] c);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 16; i++)
            r = {r[3:0], 1'b0} ^ ((r[4] ^ d[i]) ? 5'b00101 : 5'b00000);
        return r;
    endfunction

    // Serial CRC16 (x^16+x^15+x^2+1), one byte, LSB first.
    function automatic logic [15:0] crc16(input logic [7:0] d, input logic [15:0] c);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h8005 : 16'h0000);
        return r;
    endfunction

    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++)
            r[i] = v[15 - i];
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16_strip.sv
// Data-packet body path: delays the byte stream by two so the trailing CRC16
// bytes are never forwarded, and checks them against the running CRC.
module usb_crc16_strip
    import usb_decode_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       primed,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       pkt_end,
    output logic       crc_err
);

    logic [7:0]  buf0;
    logic [7:0]  buf1;
    logic [1:0]  cnt;
    logic [15:0] crc_q;
    logic [15:0] crc_next;

    assign crc_next = crc16(buf0, crc_q);
    assign primed   = (cnt != 2'd0);

    always_ff @(posedge clock) begin
        if (in_valid && !in_last) begin
            buf0 <= buf1;
            buf1 <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= 2'd0;
            crc_q     <= CRC16_INIT;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pkt_end   <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pkt_end   <= 1'b0;
            crc_err   <= 1'b0;
            if (in_valid) begin
                if (in_last) begin
                    cnt   <= 2'd0;
                    crc_q <= CRC16_INIT;
                    // CRC arrives low byte first, so the final byte is the high half.
                    if (cnt == 2'd2) begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_data  <= buf0;
                        pkt_end   <= 1'b1;
                        crc_err   <= ({in_data, buf1} != ~bitrev16(crc_next));
                    end else if (cnt == 2'd1) begin
                        pkt_end <= 1'b1;
                        crc_err <= ({in_data, buf1} != ~bitrev16(crc_q));
                    end
                end else if (cnt == 2'd2) begin
                    out_valid <= 1'b1;
                    out_data  <= buf0;
                    crc_q     <= crc_next;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/usb_decode.sv
// USB receive packet decoder: validates PIDs, classifies packets, checks
// token CRC5 and hands data bodies to the CRC16 strip stage.
module usb_decode
    import usb_decode_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_tvalid_i,
    output logic       rx_tready_o,
    input  logic       rx_tlast_i,
    input  logic [7:0] rx_tdata_i,
    output logic       hsk_recv_o,
    output logic [1:0] hsk_type_o,
    output logic       tok_recv_o,
    output logic [1:0] tok_type_o,
    output logic [6:0] tok_addr_o,
    output logic [3:0] tok_endp_o,
    output logic       trn_start_o,
    output logic [1:0] trn_type_o,
    output logic       trn_tvalid_o,
    output logic       trn_tlast_o,
    output logic [7:0] trn_tdata_o,
    output logic       trn_end_o,
    output logic       trn_crc_err_o,
    output logic       rx_err_o
);

    state_t     state;
    logic       drop_err;
    logic [7:0] b1;
    logic       acc;
    logic       pid_ok;
    logic       primed;
    logic [4:0] res5;

    assign acc    = rx_tvalid_i & rx_tready_o;
    assign pid_ok = (rx_tdata_i[7:4] == ~rx_tdata_i[3:0]);
    assign res5   = crc5({rx_tdata_i, b1}, CRC5_INIT);

    usb_crc16_strip u_strip (
        .clock    (clock),
        .reset    (reset),
        .in_data  (rx_tdata_i),
        .in_valid (acc && (state == ST_DATA)),
        .in_last  (rx_tlast_i),
        .primed   (primed),
        .out_data (trn_tdata_o),
        .out_valid(trn_tvalid_o),
        .out_last (trn_tlast_o),
        .pkt_end  (trn_end_o),
        .crc_err  (trn_crc_err_o)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            drop_err    <= 1'b0;
            b1          <= 8'd0;
            rx_tready_o <= 1'b0;
            hsk_recv_o  <= 1'b0;
            hsk_type_o  <= 2'd0;
            tok_recv_o  <= 1'b0;
            tok_type_o  <= 2'd0;
            tok_addr_o  <= 7'd0;
            tok_endp_o  <= 4'd0;
            trn_start_o <= 1'b0;
            trn_type_o  <= 2'd0;
            rx_err_o    <= 1'b0;
        end else begin
            rx_tready_o <= 1'b1;
            hsk_recv_o  <= 1'b0;
            tok_recv_o  <= 1'b0;
            trn_start_o <= 1'b0;
            rx_err_o    <= 1'b0;
            if (acc) begin
                case (state)
                    ST_IDLE: begin
                        if (!pid_ok) begin
                            if (rx_tlast_i) rx_err_o <= 1'b1;
                            else begin
                                state    <= ST_DROP;
                                drop_err <= 1'b1;
                            end
                        end else begin
                            case (pid_class_e'(rx_tdata_i[1:0]))
                                PID_HSK: begin
                                    if (rx_tlast_i) begin
                                        hsk_recv_o <= 1'b1;
                                        hsk_type_o <= rx_tdata_i[3:2];
                                    end else begin
                                        state    <= ST_DROP;
                                        drop_err <= 1'b1;
                                    end
                                end
                                PID_TOK: begin
                                    tok_type_o <= rx_tdata_i[3:2];
                                    if (rx_tlast_i) rx_err_o <= 1'b1;
                                    else state <= ST_TOK1;
                                end
                                PID_DATA: begin
                                    trn_start_o <= 1'b1;
                                    trn_type_o  <= rx_tdata_i[3:2];
                                    if (rx_tlast_i) rx_err_o <= 1'b1;
                                    else state <= ST_DATA;
                                end
                                default: begin
                                    if (rx_tlast_i) rx_err_o <= 1'b1;
                                    else begin
                                        state    <= ST_DROP;
                                        drop_err <= 1'b0;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_TOK1: begin
                        b1 <= rx_tdata_i;
                        if (rx_tlast_i) begin
                            rx_err_o <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            state <= ST_TOK2;
                        end
                    end
                    ST_TOK2: begin
                        if (!rx_tlast_i) begin
                            state    <= ST_DROP;
                            drop_err <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            if (res5 == CRC5_RESIDUAL) begin
                                tok_recv_o <= 1'b1;
                                tok_addr_o <= b1[6:0];
                                tok_endp_o <= {rx_tdata_i[2:0], b1[7]};
                            end else begin
                                rx_err_o <= 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        // The strip stage reports the end; only a body too short for a CRC is flagged here.
                        if (rx_tlast_i) begin
                            state <= ST_IDLE;
                            if (!primed) rx_err_o <= 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (rx_tlast_i) begin
                            state    <= ST_IDLE;
                            rx_err_o <= drop_err;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_decode.sv
// Bench for usb_decode: expected output events are queued as packets are
// driven and matched in order against every strobe/valid the decoder raises.
module tb_usb_decode;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_tvalid_i = 1'b0;
    logic       rx_tready_o;
    logic       rx_tlast_i = 1'b0;
    logic [7:0] rx_tdata_i = 8'd0;
    logic       hsk_recv_o;
    logic [1:0] hsk_type_o;
    logic       tok_recv_o;
    logic [1:0] tok_type_o;
    logic [6:0] tok_addr_o;
    logic [3:0] tok_endp_o;
    logic       trn_start_o;
    logic [1:0] trn_type_o;
    logic       trn_tvalid_o;
    logic       trn_tlast_o;
    logic [7:0] trn_tdata_o;
    logic       trn_end_o;
    logic       trn_crc_err_o;
    logic       rx_err_o;

    always #5 clock = ~clock;

    usb_decode dut (
        .clock        (clock),
        .reset        (reset),
        .rx_tvalid_i  (rx_tvalid_i),
        .rx_tready_o  (rx_tready_o),
        .rx_tlast_i   (rx_tlast_i),
        .rx_tdata_i   (rx_tdata_i),
        .hsk_recv_o   (hsk_recv_o),
        .hsk_type_o   (hsk_type_o),
        .tok_recv_o   (tok_recv_o),
        .tok_type_o   (tok_type_o),
        .tok_addr_o   (tok_addr_o),
        .tok_endp_o   (tok_endp_o),
        .trn_start_o  (trn_start_o),
        .trn_type_o   (trn_type_o),
        .trn_tvalid_o (trn_tvalid_o),
        .trn_tlast_o  (trn_tlast_o),
        .trn_tdata_o  (trn_tdata_o),
        .trn_end_o    (trn_end_o),
        .trn_crc_err_o(trn_crc_err_o),
        .rx_err_o     (rx_err_o)
    );

    // Event kinds: 1 handshake, 2 token, 3 data start, 4 payload byte, 5 data end, 6 error
    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] val;
    } ev_t;

    typedef struct {
        int          n;
        logic [31:0] b;
        int          ne;
        ev_t         e0;
        ev_t         e1;
    } vec_t;

    ev_t  exp_q[$];
    vec_t tv[$];
    int   checks = 0;
    int   passes = 0;
    logic [7:0] bq[$];
    ev_t  nil;

    function automatic ev_t mk(input logic [2:0] k, input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        return e;
    endfunction

    function automatic ev_t tok_ev(input logic [1:0] t, input logic [6:0] a, input logic [3:0] ep);
        return mk(3'd2, {3'd0, t, a, ep});
    endfunction

    // Reflected-form CRC5 over the 11 token bits; returns the field as transmitted.
    function automatic logic [4:0] ref_crc5(input logic [10:0] d);
        logic [4:0] r;
        r = 5'h1F;
        for (int i = 0; i < 11; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
        return ~r;
    endfunction

    function automatic logic [23:0] tok_bytes(input logic [7:0] pid, input logic [6:0] a, input logic [3:0] ep);
        logic [4:0] f;
        f = ref_crc5({ep, a});
        return {f, ep[3:1], ep[0], a, pid};
    endfunction

    function automatic logic [15:0] ref_crc16(input logic [7:0] p[$]);
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (p[i])
            for (int j = 0; j < 8; j++)
                r = (r[0] ^ p[i][j]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return ~r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    task automatic observe(input ev_t got);
        ev_t want;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got kind %0d val %h, want none", got.kind, got.val);
        end else begin
            want = exp_q.pop_front();
            chk("event", {13'd0, got}, {13'd0, want});
        end
    endtask

    always @(negedge clock) begin
        if (hsk_recv_o)   observe(mk(3'd1, {14'd0, hsk_type_o}));
        if (tok_recv_o)   observe(tok_ev(tok_type_o, tok_addr_o, tok_endp_o));
        if (trn_start_o)  observe(mk(3'd3, {14'd0, trn_type_o}));
        if (trn_tvalid_o) observe(mk(3'd4, {7'd0, trn_tlast_o, trn_tdata_o}));
        if (trn_end_o)    observe(mk(3'd5, {15'd0, trn_crc_err_o}));
        if (rx_err_o)     observe(mk(3'd6, 16'd0));
    end

    task automatic send(input logic [7:0] b[$], input int maxbub, input bit with_last);
        for (int i = 0; i < b.size(); i++) begin
            int nb;
            nb = (maxbub > 0) ? $urandom_range(maxbub, 0) : 0;
            repeat (nb) begin
                rx_tvalid_i = 1'b0;
                @(posedge clock); #1;
            end
            rx_tvalid_i = 1'b1;
            rx_tdata_i  = b[i];
            rx_tlast_i  = with_last && (i == b.size() - 1);
            @(posedge clock); #1;
        end
        rx_tvalid_i = 1'b0;
        rx_tlast_i  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic add(input int n, input logic [31:0] b, input int ne, input ev_t e0, input ev_t e1);
        vec_t v;
        v.n = n; v.b = b; v.ne = ne; v.e0 = e0; v.e1 = e1;
        tv.push_back(v);
    endtask

    task automatic data_pkt(input int len, input bit flip);
        logic [7:0]  pl[$];
        logic [7:0]  pk[$];
        logic [15:0] c;
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(255, 0)));
        c = ref_crc16(pl);
        if (flip) pl[len / 2] = pl[len / 2] ^ 8'h10;
        exp_q.push_back(mk(3'd3, 16'd0));
        for (int i = 0; i < len; i++)
            exp_q.push_back(mk(3'd4, {7'd0, (i == len - 1), pl[i]}));
        exp_q.push_back(mk(3'd5, {15'd0, flip}));
        pk.push_back(8'hC3);
        foreach (pl[i]) pk.push_back(pl[i]);
        pk.push_back(c[7:0]);
        pk.push_back(c[15:8]);
        send(pk, 2, 1'b1);
    endtask

    initial begin
        nil = mk(3'd0, 16'd0);
        add(1, 32'h000000D2, 1, mk(3'd1, 16'd0), nil);
        add(1, 32'h0000005A, 1, mk(3'd1, 16'd2), nil);
        add(1, 32'h0000001E, 1, mk(3'd1, 16'd3), nil);
        add(1, 32'h00000096, 1, mk(3'd1, 16'd1), nil);
        add(3, 32'h0010002D, 1, tok_ev(2'b11, 7'h00, 4'h0), nil);
        add(3, 32'h0011002D, 1, mk(3'd6, 16'd0), nil);
        add(3, {8'd0, tok_bytes(8'h69, 7'h15, 4'hA)}, 1, tok_ev(2'b10, 7'h15, 4'hA), nil);
        add(3, {8'd0, tok_bytes(8'hE1, 7'h7F, 4'h1)}, 1, tok_ev(2'b00, 7'h7F, 4'h1), nil);
        add(3, {8'd0, tok_bytes(8'hA5, 7'h23, 4'hB)}, 1, tok_ev(2'b01, 7'h23, 4'hB), nil);
        add(3, 32'h002211C4, 1, mk(3'd6, 16'd0), nil);
        add(1, 32'h000000D2, 1, mk(3'd1, 16'd0), nil);
        add(2, 32'h000000D2, 1, mk(3'd6, 16'd0), nil);
        add(1, 32'h00000069, 1, mk(3'd6, 16'd0), nil);
        add(4, 32'h00100069, 1, mk(3'd6, 16'd0), nil);
        add(3, 32'h0000004B, 2, mk(3'd3, 16'd2), mk(3'd5, 16'd0));
        add(2, 32'h000000C3, 2, mk(3'd3, 16'd0), mk(3'd6, 16'd0));
        add(3, 32'h003412B4, 0, nil, nil);
        add(3, 32'h0001004B, 2, mk(3'd3, 16'd2), mk(3'd5, 16'd1));

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_tready", rx_tready_o, 0);
        chk("rst_strobes", {hsk_recv_o, tok_recv_o, trn_start_o, trn_tvalid_o,
                            trn_tlast_o, trn_end_o, trn_crc_err_o, rx_err_o}, 0);
        chk("rst_fields", {hsk_type_o, tok_type_o, tok_addr_o, tok_endp_o, trn_type_o, trn_tdata_o}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("tready_up", rx_tready_o, 1);

        // Back-to-back short packets from the table
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].ne > 0) exp_q.push_back(tv[i].e0);
            if (tv[i].ne > 1) exp_q.push_back(tv[i].e1);
            bq.delete();
            for (int j = 0; j < tv[i].n; j++) bq.push_back(tv[i].b[8*j +: 8]);
            send(bq, 0, 1'b1);
        end
        drain("table_drain");

        // Data packets with bubbles, then a corrupted payload
        data_pkt(1, 1'b0);
        data_pkt(8, 1'b0);
        data_pkt(5, 1'b0);
        drain("data_drain");
        data_pkt(8, 1'b1);
        drain("crc_err_drain");

        // Reset in the middle of a data packet, then a clean ACK
        exp_q.push_back(mk(3'd3, 16'd0));
        exp_q.push_back(mk(3'd4, {8'd0, 8'h11}));
        bq.delete();
        bq.push_back(8'hC3); bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33);
        send(bq, 0, 1'b0);
        drain("pre_reset_drain");
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("mid_rst_tready", rx_tready_o, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(mk(3'd1, 16'd0));
        bq.delete();
        bq.push_back(8'hD2);
        send(bq, 0, 1'b1);
        drain("post_reset_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
